// File: rtl/dmem_responder.sv
// Data-memory responder for the ME stage: single outstanding load/store, LATENCY wait states, byte-lane writes.
// Ack arrives LATENCY+1 cycles after accept; the initiator holds iReq until oAck, then one idle cycle precedes the next accept.
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter              INIT_FILE = ""
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [3:0]  iBe,
  output logic        oAck,
  output logic [31:0] oRData,
  output logic        oErr,
  output logic        oBusy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(DEPTH) * 33'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       wait_cnt;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             accept;
  logic             resp_entry;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic [32:0]      addr_ext;
  logic             bad;
  logic [IDX_W-1:0] idx;

  // Image preload is handled by the SRAM wrapper; contents start undefined here.
  logic [31:0] mem [DEPTH];

  assign accept     = (state == S_IDLE) && iReq;
  assign resp_entry = (accept && (LATENCY == 0)) || ((state == S_WAIT) && (wait_cnt == 4'd1));

  // With zero latency the request is serviced on its accept edge, before the capture registers load.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == S_IDLE) begin
      cur_we    = iWe;
      cur_addr  = iAddr;
      cur_wdata = iWData;
      cur_be    = iBe;
    end
  end

  assign addr_ext = {1'b0, cur_addr};
  assign bad      = (cur_addr[1:0] != 2'b00) || (addr_ext < BASE_EXT) || (addr_ext >= LIMIT_EXT);
  assign idx      = IDX_W'((cur_addr - BASE_ADDR) >> 2);

  always_ff @(posedge iClk) begin
    if (nRst && resp_entry && cur_we && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_be[k]) begin
          mem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iReq) begin
            we_q     <= iWe;
            addr_q   <= iAddr;
            wdata_q  <= iWData;
            be_q     <= iBe;
            wait_cnt <= 4'(LATENCY);
            state    <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (resp_entry) begin
        err_q   <= bad;
        rdata_q <= (!cur_we && !bad) ? mem[idx] : 32'd0;
      end
    end
  end

  assign oAck   = (state == S_RESP);
  assign oRData = oAck ? rdata_q : 32'd0;
  assign oErr   = oAck & err_q;
  assign oBusy  = (state == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0 and 5) share stimulus; a scoreboard holds each expected response.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [3][64];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(32'h0000_0000), .INIT_FILE("")) u_l1 (
    .iClk(clk), .nRst(rst_n), .iReq(req[0]), .iWe(we), .iAddr(addr), .iWData(wdata), .iBe(be),
    .oAck(ack[0]), .oRData(rdata[0]), .oErr(err[0]), .oBusy(busy[0]));

  dmem_responder #(.DEPTH(64), .LATENCY(0), .BASE_ADDR(32'h0000_1000), .INIT_FILE("")) u_l0 (
    .iClk(clk), .nRst(rst_n), .iReq(req[1]), .iWe(we), .iAddr(addr), .iWData(wdata), .iBe(be),
    .oAck(ack[1]), .oRData(rdata[1]), .oErr(err[1]), .oBusy(busy[1]));

  dmem_responder #(.DEPTH(64), .LATENCY(5), .BASE_ADDR(32'h0000_0000), .INIT_FILE("")) u_l5 (
    .iClk(clk), .nRst(rst_n), .iReq(req[2]), .iWe(we), .iAddr(addr), .iWData(wdata), .iBe(be),
    .oAck(ack[2]), .oRData(rdata[2]), .oErr(err[2]), .oBusy(busy[2]));

  function automatic int lat_of(input int s);
    case (s)
      0:       return 1;
      1:       return 0;
      default: return 5;
    endcase
  endfunction

  function automatic longint base_of(input int s);
    return (s == 1) ? 64'h1000 : 64'h0;
  endfunction

  // One request on instance s; exp_cycles counts rising edges from request drive to visible ack.
  task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int exp_cycles, input bit hold, input string tag);
    exp_t   e;
    exp_t   got;
    int     cyc;
    bit     bad;
    int     idx;
    longint a_l;
    a_l = longint'(a);
    bad = (a[1:0] != 2'b00) || (a_l < base_of(s)) || (a_l >= base_of(s) + 64 * 4);
    idx = bad ? 0 : int'((a_l - base_of(s)) >> 2);
    e.err   = bad;
    e.rdata = (!w && !bad) ? mdl[s][idx] : 32'd0;
    if (w && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) mdl[s][idx][8*k +: 8] = d[8*k +: 8];
      end
    end
    sb.push_back(e);

    we = w; addr = a; wdata = d; be = b; req[s] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!ack[s] && cyc == 1) begin
        checks++;
        if (rdata[s] !== 32'd0 || err[s] !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_outputs: rdata=%h err=%b, required 0/0", tag, rdata[s], err[s]);
        end
        if (lat_of(s) > 0 && exp_cycles == lat_of(s) + 1) begin
          checks++;
          if (busy[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_wait: got %b, required 1", tag, busy[s]);
          end
        end
      end
    end while (!ack[s] && cyc < 40);

    if (!ack[s]) begin
      checks++;
      errors++;
      $display("FAIL %s ack_timeout: no ack within %0d cycles, required at %0d", tag, cyc, exp_cycles);
      void'(sb.pop_front());
      req[s] = 1'b0;
      return;
    end

    got = sb.pop_front();
    checks++;
    if (cyc !== exp_cycles) begin
      errors++;
      $display("FAIL %s ack_latency: got %0d cycles, required %0d", tag, cyc, exp_cycles);
    end
    checks++;
    if (err[s] !== got.err) begin
      errors++;
      $display("FAIL %s err: got %b, required %b", tag, err[s], got.err);
    end
    checks++;
    if (rdata[s] !== got.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h, required %h", tag, rdata[s], got.rdata);
    end

    if (!hold) begin
      req[s] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ack[s] !== 1'b0) begin
        errors++;
        $display("FAIL %s ack_pulse: ack still %b one cycle later, required 0", tag, ack[s]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b000; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (ack[s] !== 1'b0 || busy[s] !== 1'b0 || rdata[s] !== 32'd0 || err[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: ack=%b busy=%b rdata=%h err=%b, required all 0",
                 s, ack[s], busy[s], rdata[s], err[s]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, "st_10");
    xact(0, 1'b0, 32'h10, 32'h0,         4'hF, 2, 1'b0, "ld_10");
    checks++;
    if (mdl[0][4] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL model_word10: got %h, required deadbeef", mdl[0][4]);
    end
  endtask

  task automatic test_byte_lanes();
    xact(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF,    2, 1'b0, "st_20_full");
    xact(0, 1'b1, 32'h20, 32'h0000_AA00, 4'b0010, 2, 1'b0, "st_20_lane1");
    xact(0, 1'b0, 32'h20, 32'h0,         4'h0,    2, 1'b0, "ld_20_merge");
    checks++;
    if (mdl[0][8] !== 32'h1122_AA44) begin
      errors++;
      $display("FAIL model_word20: got %h, required 1122aa44", mdl[0][8]);
    end
    xact(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0,    2, 1'b0, "st_20_noop");
    xact(0, 1'b0, 32'h20, 32'h0,         4'h0,    2, 1'b0, "ld_20_after_noop");
  endtask

  task automatic test_errors();
    xact(0, 1'b1, 32'h0,   32'hCAFE_F00D, 4'hF, 2, 1'b0, "st_00");
    xact(0, 1'b0, 32'h13,  32'h0,         4'h0, 2, 1'b0, "ld_misaligned");
    xact(0, 1'b1, 32'h13,  32'h5555_5555, 4'hF, 2, 1'b0, "st_misaligned");
    xact(0, 1'b0, 32'h100, 32'h0,         4'h0, 2, 1'b0, "ld_past_end");
    xact(0, 1'b1, 32'h100, 32'h7777_7777, 4'hF, 2, 1'b0, "st_past_end");
    xact(0, 1'b0, 32'h10,  32'h0,         4'h0, 2, 1'b0, "ld_10_untouched");
    xact(0, 1'b0, 32'h0,   32'h0,         4'h0, 2, 1'b0, "ld_00_no_wrap");
    xact(1, 1'b0, 32'hFFC,  32'h0,        4'h0, 1, 1'b0, "ld_below_base");
    xact(1, 1'b0, 32'h1100, 32'h0,        4'h0, 1, 1'b0, "ld_base_past_end");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b1, 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i * 32'h0101), 4'hF, 1, 1'b0, "b2b_fill");
    end
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, (i == 0) ? 1 : 2, (i != 3), "b2b_load");
    end
  endtask

  task automatic test_reset_mid_wait();
    bit saw_ack;
    xact(2, 1'b1, 32'h40, 32'hA5A5_0F0F, 4'hF, 6, 1'b0, "l5_st_40");
    we = 1'b1; addr = 32'h40; wdata = 32'h1234_5678; be = 4'hF; req[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait busy_before_reset: got %b, required 1", busy[2]);
    end
    rst_n = 1'b0;
    req[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait busy_after_reset: got %b, required 0", busy[2]);
    end
    saw_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack[2] === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      errors++;
      $display("FAIL rst_wait dropped_request: ack seen=1, required 0");
    end
    xact(2, 1'b0, 32'h40, 32'h0, 4'h0, 6, 1'b0, "l5_ld_40_unchanged");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
